// File: rtl/fpu_pkg.sv
// Shared FPU definitions: binary32 field layout, exception flag bundle and
// the divide sequencer state encoding.
package fpu_pkg;

   localparam int unsigned EXP_W  = 8;
   localparam int unsigned FRAC_W = 23;
   localparam int unsigned BIAS   = 127;
   localparam logic [31:0] QNAN   = 32'h7FC0_0000;

   typedef struct packed {
      logic invalid;
      logic div_by_zero;
      logic overflow;
      logic underflow;
      logic inexact;
   } fp_flags_t;

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StDivide,
      StRound,
      StDone
   } div_state_t;

endpackage

// File: rtl/fpu_div_ctrl_nrd_division.sv
// Combinational non-restoring mantissa divider; the caller treats it as a
// multicycle path and holds the inputs stable until the outputs are sampled.
module NRD_Division #(
   parameter int unsigned DIVIDEND_LENGTH = 24,
   parameter int unsigned DIVISOR_LENGTH  = 24,
   parameter int unsigned QUOTIENT_LENGTH = 24
) (
   input  logic [DIVIDEND_LENGTH-1:0] dividend,
   input  logic [DIVISOR_LENGTH-1:0]  divisor,
   input  logic                       ge,
   output logic [QUOTIENT_LENGTH-1:0] quotient,
   output logic [DIVISOR_LENGTH-1:0]  remainder
);

   localparam int unsigned PW = DIVISOR_LENGTH + 3;

   logic signed [PW-1:0] p;
   logic signed [PW-1:0] d;

   always_comb begin
      d        = PW'(divisor);
      p        = PW'(dividend);
      quotient = '0;
      // A dividend smaller than the divisor is pre-doubled so the quotient MSB is always 1.
      if (!ge) begin
         p = p <<< 1;
      end
      for (int i = QUOTIENT_LENGTH - 1; i >= 0; i--) begin
         if (!p[PW-1]) begin
            p = p - d;
         end else begin
            p = p + d;
         end
         quotient[i] = ~p[PW-1];
         if (i > 0) begin
            p = p <<< 1;
         end
      end
      if (p[PW-1]) begin
         p = p + d;
      end
      remainder = p[DIVISOR_LENGTH-1:0];
   end

endmodule

// File: rtl/fpu_div_ctrl.sv
// Single-precision divide sequencer: operand handshake, special-case filter,
// multicycle divider control, round-to-nearest-even and result packing.
module fpu_div_ctrl
   import fpu_pkg::*;
#(
   parameter int unsigned DIV_CYCLES = 4,
   parameter int unsigned MANT_W     = 24
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic [4:0]  flags,
   output logic        busy
);

   div_state_t state_q, state_d;

   logic [31:0]              a_q, b_q;
   logic                     sign_q;
   logic signed [9:0]        exp_q;
   logic [MANT_W-1:0]        ma_q, mb_q;
   logic                     ge_q;
   logic [3:0]               cnt_q;
   logic [MANT_W-1:0]        q_q, r_q;
   logic                     special_q;
   logic [31:0]              spec_res_q;
   fp_flags_t                spec_flags_q;
   logic [31:0]              result_q;
   fp_flags_t                flags_q;

   logic [MANT_W-1:0]        quotient, remainder;
   logic                     div_last;

   // Operand unpack
   logic [EXP_W-1:0]  ea, eb;
   logic [FRAC_W-1:0] fa, fb;
   logic              sign;
   logic              nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
   logic [MANT_W-1:0] ma, mb;
   logic              ge;
   logic [9:0]        exp_setup;

   assign ea     = a_q[EXP_W+FRAC_W-1:FRAC_W];
   assign eb     = b_q[EXP_W+FRAC_W-1:FRAC_W];
   assign fa     = a_q[FRAC_W-1:0];
   assign fb     = b_q[FRAC_W-1:0];
   assign sign   = a_q[31] ^ b_q[31];
   assign nan_a  = (ea == '1) && (fa != '0);
   assign nan_b  = (eb == '1) && (fb != '0);
   assign inf_a  = (ea == '1) && (fa == '0);
   assign inf_b  = (eb == '1) && (fb == '0);
   assign zero_a = (ea == '0);
   assign zero_b = (eb == '0);
   assign ma     = {1'b1, fa};
   assign mb     = {1'b1, fb};
   assign ge     = (ma >= mb);
   assign exp_setup = {2'b00, ea} - {2'b00, eb} + 10'(BIAS) - {9'd0, ~ge};

   logic        spec_hit;
   logic [31:0] spec_res;
   fp_flags_t   spec_flags;

   always_comb begin
      spec_hit   = 1'b1;
      spec_res   = '0;
      spec_flags = '0;
      if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b)) begin
         spec_res           = QNAN;
         spec_flags.invalid = 1'b1;
      end else if (zero_b && !inf_a) begin
         spec_res               = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
         spec_flags.div_by_zero = 1'b1;
      end else if (inf_a) begin
         spec_res = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      end else if (zero_a || inf_b) begin
         spec_res = {sign, 31'd0};
      end else begin
         spec_hit = 1'b0;
      end
   end

   NRD_Division #(
      .DIVIDEND_LENGTH (MANT_W),
      .DIVISOR_LENGTH  (MANT_W),
      .QUOTIENT_LENGTH (MANT_W)
   ) u_nrd (
      .dividend  (ma_q),
      .divisor   (mb_q),
      .ge        (ge_q),
      .quotient  (quotient),
      .remainder (remainder)
   );

   assign div_last = (cnt_q == 4'(DIV_CYCLES - 1));

   // Rounding: r is the remainder against mb at the quotient's own scale, so 2r vs mb is the
   // half-ulp test whether or not the dividend was pre-doubled.
   logic [MANT_W:0]   twice_r;
   logic              round_up;
   logic [MANT_W:0]   q_inc;
   logic signed [9:0] exp_r;
   logic [31:0]       rnd_res;
   fp_flags_t         rnd_flags;

   always_comb begin
      twice_r   = {r_q, 1'b0};
      round_up  = (twice_r > {1'b0, mb_q}) || ((twice_r == {1'b0, mb_q}) && q_q[0]);
      q_inc     = {1'b0, q_q} + {{MANT_W{1'b0}}, round_up};
      exp_r     = exp_q + {9'd0, q_inc[MANT_W]};
      rnd_flags = '0;
      rnd_flags.inexact = (r_q != '0);
      rnd_res   = {sign_q, exp_r[EXP_W-1:0], q_inc[FRAC_W-1:0]};
      if (exp_r >= 10'sd255) begin
         rnd_res             = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
         rnd_flags.overflow  = 1'b1;
         rnd_flags.inexact   = 1'b1;
      end else if (exp_r <= 10'sd0) begin
         rnd_res             = {sign_q, 31'd0};
         rnd_flags.underflow = 1'b1;
         rnd_flags.inexact   = 1'b1;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state; specials skip the divider but share ROUND so results land at one point
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (in_valid) state_d = StSetup;
         StSetup:  state_d = spec_hit ? StRound : StDivide;
         StDivide: if (div_last) state_d = StRound;
         StRound:  state_d = StDone;
         StDone:   if (out_ready) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Outputs
   always_comb begin
      in_ready  = (state_q == StIdle) && rst_n;
      out_valid = (state_q == StDone);
      busy      = (state_q != StIdle);
      result    = result_q;
      flags     = flags_q;
   end

   // Datapath
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_q          <= '0;
         b_q          <= '0;
         sign_q       <= 1'b0;
         exp_q        <= '0;
         ma_q         <= '0;
         mb_q         <= '0;
         ge_q         <= 1'b0;
         cnt_q        <= '0;
         q_q          <= '0;
         r_q          <= '0;
         special_q    <= 1'b0;
         spec_res_q   <= '0;
         spec_flags_q <= '0;
         result_q     <= '0;
         flags_q      <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (in_valid) begin
                  a_q     <= op_a;
                  b_q     <= op_b;
                  flags_q <= '0;
               end
            end
            StSetup: begin
               sign_q       <= sign;
               exp_q        <= exp_setup;
               ma_q         <= ma;
               mb_q         <= mb;
               ge_q         <= ge;
               cnt_q        <= '0;
               special_q    <= spec_hit;
               spec_res_q   <= spec_res;
               spec_flags_q <= spec_flags;
            end
            StDivide: begin
               cnt_q <= cnt_q + 4'd1;
               if (div_last) begin
                  q_q <= quotient;
                  r_q <= remainder;
               end
            end
            StRound: begin
               result_q <= special_q ? spec_res_q : rnd_res;
               flags_q  <= special_q ? spec_flags_q : rnd_flags;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_div_ctrl.sv
// Directed bench for fpu_div_ctrl: latency, rounding, specials, range limits,
// back-pressure and mid-operation reset.
module tb_fpu_div_ctrl;

   localparam int unsigned DIV_CYCLES = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] op_a, op_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic [4:0]  flags;
   logic        busy;

   int n_cmp = 0;
   int n_err = 0;

   localparam logic [4:0] F_INV = 5'b10000;
   localparam logic [4:0] F_DZ  = 5'b01000;
   localparam logic [4:0] F_OVF = 5'b00100;
   localparam logic [4:0] F_UNF = 5'b00010;
   localparam logic [4:0] F_INX = 5'b00001;

   fpu_div_ctrl #(
      .DIV_CYCLES (DIV_CYCLES),
      .MANT_W     (24)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Issue one operation, wait (bounded) for out_valid, capture and accept it.
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, output logic [31:0] res,
                        output logic [4:0] flg, output int lat);
      @(negedge clk);
      op_a = a;
      op_b = b;
      in_valid = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = -1;
      res = 'x;
      flg = 'x;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (out_valid) begin
            lat = i;
            break;
         end
      end
      if (lat > 0) begin
         res = result;
         flg = flags;
         out_ready = 1'b1;
         @(posedge clk);
         #1 out_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      op_a = '0;
      op_b = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready_low: got %b want 0", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL reset_result: got %h want 0", result); end
      n_cmp++; if (flags !== 5'h0) begin n_err++; $display("FAIL reset_flags: got %b want 0", flags); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready_high: got %b want 1", in_ready); end
   endtask

   task automatic test_normal();
      logic [31:0] r; logic [4:0] f; int lat;
      do_op(32'h40C00000, 32'h40000000, r, f, lat);
      n_cmp++; if (r !== 32'h40400000) begin n_err++; $display("FAIL six_by_two_result: got %h want 40400000", r); end
      n_cmp++; if (f !== 5'h0) begin n_err++; $display("FAIL six_by_two_flags: got %b want 00000", f); end
      n_cmp++; if (lat !== DIV_CYCLES + 2) begin n_err++; $display("FAIL six_by_two_latency: got %0d want %0d", lat, DIV_CYCLES + 2); end
      do_op(32'hC0C00000, 32'h40000000, r, f, lat);
      n_cmp++; if (r !== 32'hC0400000) begin n_err++; $display("FAIL neg_six_by_two_result: got %h want c0400000", r); end
   endtask

   task automatic test_rounding();
      logic [31:0] r; logic [4:0] f; int lat;
      do_op(32'h3F800000, 32'h40400000, r, f, lat);
      n_cmp++; if (r !== 32'h3EAAAAAB) begin n_err++; $display("FAIL one_third_result: got %h want 3eaaaaab", r); end
      n_cmp++; if (f !== F_INX) begin n_err++; $display("FAIL one_third_flags: got %b want 00001", f); end
      do_op(32'h3F800000, 32'h3F800000, r, f, lat);
      n_cmp++; if (r !== 32'h3F800000) begin n_err++; $display("FAIL one_by_one_result: got %h want 3f800000", r); end
      n_cmp++; if (f !== 5'h0) begin n_err++; $display("FAIL one_by_one_flags: got %b want 00000", f); end
   endtask

   task automatic test_special();
      logic [31:0] r; logic [4:0] f; int lat;
      do_op(32'h3F800000, 32'h00000000, r, f, lat);
      n_cmp++; if (r !== 32'h7F800000) begin n_err++; $display("FAIL div_zero_result: got %h want 7f800000", r); end
      n_cmp++; if (f !== F_DZ) begin n_err++; $display("FAIL div_zero_flags: got %b want 01000", f); end
      n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL div_zero_latency: got %0d want 2", lat); end
      do_op(32'h00000000, 32'h00000000, r, f, lat);
      n_cmp++; if (r !== 32'h7FC00000) begin n_err++; $display("FAIL zero_zero_result: got %h want 7fc00000", r); end
      n_cmp++; if (f !== F_INV) begin n_err++; $display("FAIL zero_zero_flags: got %b want 10000", f); end
      n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL zero_zero_latency: got %0d want 2", lat); end
      do_op(32'hFF800000, 32'h40000000, r, f, lat);
      n_cmp++; if (r !== 32'hFF800000 || f !== 5'h0) begin n_err++; $display("FAIL inf_by_x: got %h/%b want ff800000/00000", r, f); end
      do_op(32'h40000000, 32'h7F800000, r, f, lat);
      n_cmp++; if (r !== 32'h00000000 || f !== 5'h0) begin n_err++; $display("FAIL x_by_inf: got %h/%b want 00000000/00000", r, f); end
      do_op(32'h7FC00001, 32'h3F800000, r, f, lat);
      n_cmp++; if (r !== 32'h7FC00000 || f !== F_INV) begin n_err++; $display("FAIL nan_in: got %h/%b want 7fc00000/10000", r, f); end
   endtask

   task automatic test_range();
      logic [31:0] r; logic [4:0] f; int lat;
      do_op(32'h7F000000, 32'h3E800000, r, f, lat);
      n_cmp++; if (r !== 32'h7F800000) begin n_err++; $display("FAIL overflow_result: got %h want 7f800000", r); end
      n_cmp++; if (f !== (F_OVF | F_INX)) begin n_err++; $display("FAIL overflow_flags: got %b want 00101", f); end
      do_op(32'h00800000, 32'h40000000, r, f, lat);
      n_cmp++; if (r !== 32'h00000000) begin n_err++; $display("FAIL underflow_result: got %h want 00000000", r); end
      n_cmp++; if (f !== (F_UNF | F_INX)) begin n_err++; $display("FAIL underflow_flags: got %b want 00011", f); end
   endtask

   task automatic test_backpressure();
      logic [31:0] r; logic [4:0] f; int lat;
      lat = -1;
      @(negedge clk);
      op_a = 32'h40C00000;
      op_b = 32'h40000000;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (out_valid) begin
            lat = i;
            break;
         end
      end
      n_cmp++; if (lat !== DIV_CYCLES + 2) begin n_err++; $display("FAIL bp_latency: got %0d want %0d", lat, DIV_CYCLES + 2); end
      for (int i = 0; i < 10; i++) begin
         n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out_valid_%0d: got %b want 1", i, out_valid); end
         n_cmp++; if (result !== 32'h40400000) begin n_err++; $display("FAIL bp_result_%0d: got %h want 40400000", i, result); end
         n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready_%0d: got %b want 0", i, in_ready); end
         if (i == 3) begin
            op_a = 32'h3F800000;
            op_b = 32'h40400000;
            in_valid = 1'b1;
         end
         @(negedge clk);
         in_valid = 1'b0;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         n_err++; $display("FAIL bp_release: got ov=%b ir=%b busy=%b want 0/1/0", out_valid, in_ready, busy);
      end
      do_op(32'h3F800000, 32'h3F800000, r, f, lat);
      n_cmp++; if (r !== 32'h3F800000 || f !== 5'h0) begin n_err++; $display("FAIL bp_next_op: got %h/%b want 3f800000/00000", r, f); end
   endtask

   task automatic test_reset_mid_divide();
      logic [31:0] r; logic [4:0] f; int lat; int seen;
      seen = 0;
      @(negedge clk);
      op_a = 32'h3F800000;
      op_b = 32'h40400000;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy_before_reset: got %b want 1", busy); end
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0 || in_ready !== 1'b1) begin
         n_err++; $display("FAIL mid_reset_idle: got busy=%b ir=%b want 0/1", busy, in_ready);
      end
      n_cmp++; if (result !== 32'h0 || flags !== 5'h0) begin
         n_err++; $display("FAIL mid_reset_cleared: got %h/%b want 00000000/00000", result, flags);
      end
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL mid_reset_no_out_valid: got %0d cycles want 0", seen); end
      do_op(32'h40C00000, 32'h40000000, r, f, lat);
      n_cmp++; if (r !== 32'h40400000 || f !== 5'h0) begin n_err++; $display("FAIL mid_reset_next_op: got %h/%b want 40400000/00000", r, f); end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_rounding();
      test_special();
      test_range();
      test_backpressure();
      test_reset_mid_divide();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
